// File: rtl/control_pipe_if.sv
// Bundle of Decode-stage control inputs, hazard controls and staged E/M/W outputs.
// Ports: master drives the D-stage controls and hazard bits and observes the
//        stage outputs and counters; slave is the pipeline register block.
interface control_pipe_if #(
  parameter int CNT_W = 32,
  parameter int BUB_W = 16
);
  // Decode-stage controls from the control unit
  logic             i_ValidD;
  logic             i_RegWriteD;
  logic             i_MemtoRegD;
  logic             i_MemWriteD;
  logic             i_ALUSrcD;
  logic             i_RegDstD;
  logic [2:0]       i_ALUControlD;
  // Hazard-unit controls
  logic             i_FlushE;
  logic             i_StallE;
  // Execute stage
  logic             o_ValidE;
  logic             o_RegWriteE;
  logic             o_MemtoRegE;
  logic             o_MemWriteE;
  logic             o_ALUSrcE;
  logic             o_RegDstE;
  logic [2:0]       o_ALUControlE;
  // Memory stage
  logic             o_ValidM;
  logic             o_RegWriteM;
  logic             o_MemtoRegM;
  logic             o_MemWriteM;
  // Writeback stage
  logic             o_ValidW;
  logic             o_RegWriteW;
  logic             o_MemtoRegW;
  // Event counters
  logic [CNT_W-1:0] o_RetireCount;
  logic [BUB_W-1:0] o_BubbleCount;

  modport master (
    output i_ValidD, i_RegWriteD, i_MemtoRegD, i_MemWriteD, i_ALUSrcD,
           i_RegDstD, i_ALUControlD, i_FlushE, i_StallE,
    input  o_ValidE, o_RegWriteE, o_MemtoRegE, o_MemWriteE, o_ALUSrcE,
           o_RegDstE, o_ALUControlE, o_ValidM, o_RegWriteM, o_MemtoRegM,
           o_MemWriteM, o_ValidW, o_RegWriteW, o_MemtoRegW,
           o_RetireCount, o_BubbleCount
  );

  modport slave (
    input  i_ValidD, i_RegWriteD, i_MemtoRegD, i_MemWriteD, i_ALUSrcD,
           i_RegDstD, i_ALUControlD, i_FlushE, i_StallE,
    output o_ValidE, o_RegWriteE, o_MemtoRegE, o_MemWriteE, o_ALUSrcE,
           o_RegDstE, o_ALUControlE, o_ValidM, o_RegWriteM, o_MemtoRegM,
           o_MemWriteM, o_ValidW, o_RegWriteW, o_MemtoRegW,
           o_RetireCount, o_BubbleCount
  );
endinterface

// File: rtl/control_pipe.sv
// Control-signal pipeline D->E->M->W with flush/stall bubbles, retire and bubble counters.
// Latency: D->E 1 cycle, D->M 2, D->W 3; every output comes straight from a flop.
// Backpressure: i_StallE holds E and feeds bubbles into M; i_FlushE bubbles E and wins over stall.
// Ports: i_CLK clock, i_RST async active-high reset, bus (slave modport) carries the
//        D-stage controls, hazard controls, staged E/M/W controls and the two counters.
module control_pipe #(
  parameter int CNT_W = 32,
  parameter int BUB_W = 16
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  control_pipe_if.slave bus
);

  // Each stage only carries the controls still needed from that stage onward.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       memto_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_control;
  } e_slot_t;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic memto_reg;
    logic mem_write;
  } m_slot_t;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic memto_reg;
  } w_slot_t;

  e_slot_t          d_slot;
  e_slot_t          e_d, e_q;
  m_slot_t          m_d, m_q;
  w_slot_t          w_d, w_q;
  logic [CNT_W-1:0] retire_d, retire_q;
  logic [BUB_W-1:0] bubble_d, bubble_q;

  // An invalid D slot is squashed to an all-zero bubble so stray control bits
  // from the decoder can never reach RegWrite/MemWrite downstream.
  always_comb begin
    d_slot = '0;
    if (bus.i_ValidD) begin
      d_slot.valid       = 1'b1;
      d_slot.reg_write   = bus.i_RegWriteD;
      d_slot.memto_reg   = bus.i_MemtoRegD;
      d_slot.mem_write   = bus.i_MemWriteD;
      d_slot.alu_src     = bus.i_ALUSrcD;
      d_slot.reg_dst     = bus.i_RegDstD;
      d_slot.alu_control = bus.i_ALUControlD;
    end
  end

  always_comb begin
    // E: flush beats stall; stall holds the current slot.
    e_d = e_q;
    if (bus.i_FlushE) begin
      e_d = '0;
    end else if (!bus.i_StallE) begin
      e_d = d_slot;
    end

    // M: while E is held, the held instruction must not also advance, so M
    // takes a bubble. Under flush the old E content moves on normally.
    m_d.valid     = e_q.valid;
    m_d.reg_write = e_q.reg_write;
    m_d.memto_reg = e_q.memto_reg;
    m_d.mem_write = e_q.mem_write;
    if (bus.i_StallE && !bus.i_FlushE) begin
      m_d = '0;
    end

    // W never stalls or flushes.
    w_d.valid     = m_q.valid;
    w_d.reg_write = m_q.reg_write;
    w_d.memto_reg = m_q.memto_reg;

    // Retire counts what is entering W this edge; wraps naturally.
    retire_d = retire_q + CNT_W'(m_q.valid);

    // One bubble per hazard cycle, saturating at all-ones.
    bubble_d = bubble_q;
    if ((bus.i_FlushE || bus.i_StallE) && (bubble_q != {BUB_W{1'b1}})) begin
      bubble_d = bubble_q + BUB_W'(1);
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      retire_q <= '0;
      bubble_q <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      retire_q <= retire_d;
      bubble_q <= bubble_d;
    end
  end

  assign bus.o_ValidE      = e_q.valid;
  assign bus.o_RegWriteE   = e_q.reg_write;
  assign bus.o_MemtoRegE   = e_q.memto_reg;
  assign bus.o_MemWriteE   = e_q.mem_write;
  assign bus.o_ALUSrcE     = e_q.alu_src;
  assign bus.o_RegDstE     = e_q.reg_dst;
  assign bus.o_ALUControlE = e_q.alu_control;

  assign bus.o_ValidM      = m_q.valid;
  assign bus.o_RegWriteM   = m_q.reg_write;
  assign bus.o_MemtoRegM   = m_q.memto_reg;
  assign bus.o_MemWriteM   = m_q.mem_write;

  assign bus.o_ValidW      = w_q.valid;
  assign bus.o_RegWriteW   = w_q.reg_write;
  assign bus.o_MemtoRegW   = w_q.memto_reg;

  assign bus.o_RetireCount = retire_q;
  assign bus.o_BubbleCount = bubble_q;

endmodule

// File: tb/tb_control_pipe.sv
module tb_control_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_pipe_if #(.CNT_W(32), .BUB_W(16)) bus0 ();
  control_pipe_if #(.CNT_W(4),  .BUB_W(4))  bus1 ();

  control_pipe #(.CNT_W(32), .BUB_W(16)) dut0 (.i_CLK(clk), .i_RST(rst), .bus(bus0));
  control_pipe #(.CNT_W(4),  .BUB_W(4))  dut1 (.i_CLK(clk), .i_RST(rst), .bus(bus1));

  // Instruction control word: {valid, regwrite, memtoreg, memwrite, alusrc, regdst, aluctl}
  typedef struct packed {
    logic       v;
    logic       rw;
    logic       m2r;
    logic       mw;
    logic       asrc;
    logic       rdst;
    logic [2:0] alu;
  } slot_t;

  localparam slot_t NONE = 9'b0_0_0_0_0_0_000;
  localparam slot_t LW   = 9'b1_1_1_0_1_0_010;
  localparam slot_t SW   = 9'b1_0_0_1_1_0_010;
  localparam slot_t ADD  = 9'b1_1_0_0_0_1_010;
  localparam slot_t SUB  = 9'b1_1_0_0_0_1_110;
  localparam slot_t JUNK = 9'b0_1_1_1_1_1_111;

  typedef struct {
    slot_t      d;
    logic       f;
    logic       s;
    slot_t      e_exp;
    logic [3:0] m_exp;   // {v, rw, m2r, mw}
    logic [2:0] w_exp;   // {v, rw, m2r}
    int         ret;
    int         bub;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive0(input slot_t d, input logic f, input logic s);
    bus0.i_ValidD      = d.v;
    bus0.i_RegWriteD   = d.rw;
    bus0.i_MemtoRegD   = d.m2r;
    bus0.i_MemWriteD   = d.mw;
    bus0.i_ALUSrcD     = d.asrc;
    bus0.i_RegDstD     = d.rdst;
    bus0.i_ALUControlD = d.alu;
    bus0.i_FlushE      = f;
    bus0.i_StallE      = s;
  endtask

  task automatic drive1(input slot_t d, input logic f, input logic s);
    bus1.i_ValidD      = d.v;
    bus1.i_RegWriteD   = d.rw;
    bus1.i_MemtoRegD   = d.m2r;
    bus1.i_MemWriteD   = d.mw;
    bus1.i_ALUSrcD     = d.asrc;
    bus1.i_RegDstD     = d.rdst;
    bus1.i_ALUControlD = d.alu;
    bus1.i_FlushE      = f;
    bus1.i_StallE      = s;
  endtask

  function automatic slot_t e0();
    return {bus0.o_ValidE, bus0.o_RegWriteE, bus0.o_MemtoRegE, bus0.o_MemWriteE,
            bus0.o_ALUSrcE, bus0.o_RegDstE, bus0.o_ALUControlE};
  endfunction

  function automatic logic [63:0] obs0();
    return {e0(),
            bus0.o_ValidM, bus0.o_RegWriteM, bus0.o_MemtoRegM, bus0.o_MemWriteM,
            bus0.o_ValidW, bus0.o_RegWriteW, bus0.o_MemtoRegW,
            bus0.o_RetireCount, bus0.o_BubbleCount};
  endfunction

  function automatic vec_t mk(slot_t d, logic f, logic s, slot_t e, logic [3:0] m,
                              logic [2:0] w, int ret, int bub);
    vec_t r;
    r.d = d; r.f = f; r.s = s; r.e_exp = e; r.m_exp = m; r.w_exp = w;
    r.ret = ret; r.bub = bub;
    return r;
  endfunction

  vec_t tbl[11];

  // Reference model: instruction slots in each stage plus plain event tallies.
  slot_t       me, mm, mwb;
  int unsigned rcnt;
  int          bcnt;

  function automatic logic [63:0] model_obs();
    logic [15:0] bsat;
    bsat = (bcnt > 65535) ? 16'hFFFF : 16'(bcnt);
    return {me, mm.v, mm.rw, mm.m2r, mm.mw, mwb.v, mwb.rw, mwb.m2r, 32'(rcnt), bsat};
  endfunction

  initial begin
    drive0(NONE, 1'b0, 1'b0);
    drive1(NONE, 1'b0, 1'b0);

    //                 D     F     S     E     M        W       ret bub
    tbl[0]  = mk(LW,   1'b0, 1'b0, LW,   4'b0000, 3'b000, 0, 0);
    tbl[1]  = mk(SW,   1'b1, 1'b0, NONE, 4'b1110, 3'b000, 0, 1);
    tbl[2]  = mk(ADD,  1'b0, 1'b0, ADD,  4'b0000, 3'b111, 1, 1);
    tbl[3]  = mk(SUB,  1'b0, 1'b1, ADD,  4'b0000, 3'b000, 1, 2);
    tbl[4]  = mk(SUB,  1'b0, 1'b1, ADD,  4'b0000, 3'b000, 1, 3);
    tbl[5]  = mk(SUB,  1'b0, 1'b0, SUB,  4'b1100, 3'b000, 1, 3);
    tbl[6]  = mk(JUNK, 1'b0, 1'b0, NONE, 4'b1100, 3'b110, 2, 3);
    tbl[7]  = mk(SW,   1'b1, 1'b1, NONE, 4'b0000, 3'b110, 3, 4);
    tbl[8]  = mk(SW,   1'b0, 1'b0, SW,   4'b0000, 3'b000, 3, 4);
    tbl[9]  = mk(LW,   1'b1, 1'b1, NONE, 4'b1001, 3'b000, 3, 5);
    tbl[10] = mk(NONE, 1'b0, 1'b0, NONE, 4'b0000, 3'b100, 4, 5);

    // Reset state
    #2;
    chk("reset_obs", obs0(), 64'h0);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      logic [63:0] o;
      drive0(tbl[i].d, tbl[i].f, tbl[i].s);
      @(negedge clk);
      o = obs0();
      chk($sformatf("tbl%0d_E", i), 64'(o[63:55]), 64'(tbl[i].e_exp));
      chk($sformatf("tbl%0d_M", i), 64'(o[54:51]), 64'(tbl[i].m_exp));
      chk($sformatf("tbl%0d_W", i), 64'(o[50:48]), 64'(tbl[i].w_exp));
      chk($sformatf("tbl%0d_ret", i), 64'(bus0.o_RetireCount), 64'(tbl[i].ret));
      chk($sformatf("tbl%0d_bub", i), 64'(bus0.o_BubbleCount), 64'(tbl[i].bub));
    end

    // Three valid slots in flight, then an async reset between edges
    drive0(LW, 1'b0, 1'b0);
    @(negedge clk);
    drive0(ADD, 1'b0, 1'b0);
    @(negedge clk);
    drive0(SW, 1'b0, 1'b0);
    @(negedge clk);
    chk("inflight_valid", {61'b0, bus0.o_ValidE, bus0.o_ValidM, bus0.o_ValidW}, 64'h7);
    chk("inflight_ret", 64'(bus0.o_RetireCount), 64'd5);
    drive0(NONE, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk("async_rst_obs", obs0(), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive0(ADD, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_E", 64'(e0()), 64'(ADD));
    chk("post_rst_cnt", {32'b0, bus0.o_RetireCount[15:0], bus0.o_BubbleCount}, 64'h0);

    // Randomized run against the reference model
    drive0(NONE, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    me = NONE; mm = NONE; mwb = NONE; rcnt = 0; bcnt = 0;
    for (int i = 0; i < 1500; i++) begin
      slot_t d, din;
      logic  f, s;
      d   = slot_t'($urandom_range(0, 511));
      d.v = ($urandom_range(0, 4) != 0);
      f   = ($urandom_range(0, 9) == 0);
      s   = ($urandom_range(0, 4) == 0);
      drive0(d, f, s);
      din = d.v ? d : NONE;
      if (mm.v) rcnt++;
      if (f || s) bcnt++;
      mwb = mm;
      mm  = (s && !f) ? NONE : me;
      me  = f ? NONE : (s ? me : din);
      @(negedge clk);
      chk($sformatf("rand%0d", i), obs0(), model_obs());
    end
    drive0(NONE, 1'b0, 1'b0);

    // Narrow build: bubble saturation and retire wrap
    drive1(NONE, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) @(negedge clk);
    chk("sat_bub_15", 64'(bus1.o_BubbleCount), 64'd15);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("sat_bub_hold", 64'(bus1.o_BubbleCount), 64'd15);
    chk("sat_no_retire", 64'(bus1.o_RetireCount), 64'd0);
    drive1(ADD, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) @(negedge clk);
    drive1(NONE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("wrap_ret", 64'(bus1.o_RetireCount), 64'd1);
    chk("wrap_bub", 64'(bus1.o_BubbleCount), 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 Parameter BUB_W, default 16: width of the bubble counter.
REQ-003 i_CLK  input  1  single clock; all state updates on rising edge.
REQ-004 i_RST  input  1  reset, asynchronous, active-high.
REQ-005 i_ValidD  input  1  Decode-stage slot holds a real instruction.
REQ-006 i_RegWriteD, i_MemtoRegD, i_MemWriteD, i_ALUSrcD, i_RegDstD  input  1 each  decoded control bits from the control unit.
REQ-007 i_ALUControlD  input  3  decoded ALU operation.
REQ-008 i_FlushE  input  1  hazard unit: turn the Execute slot into a bubble.
REQ-009 i_StallE  input  1  hazard unit: hold the Execute slot.
REQ-010 o_ValidE, o_RegWriteE, o_MemtoRegE, o_MemWriteE, o_ALUSrcE, o_RegDstE  output  1 each  Execute-stage controls.
REQ-011 o_ALUControlE  output  3  Execute-stage ALU operation.
REQ-012 o_ValidM, o_RegWriteM, o_MemtoRegM, o_MemWriteM  output  1 each  Memory-stage controls.
REQ-013 o_ValidW, o_RegWriteW, o_MemtoRegW  output  1 each  Writeback-stage controls.
REQ-014 o_RetireCount  output  CNT_W  count of valid instructions that have entered W.
REQ-015 o_BubbleCount  output  BUB_W  count of bubbles inserted by flush or stall.

Function
REQ-016 Three register stages D->E, E->M, M->W; each output is a direct register output, no combinational input-to-output path.
REQ-017 A bubble is a slot with Valid=0 and every control bit and ALUControl = 0; a bubble never asserts RegWrite or MemWrite downstream.
REQ-018 E stage, priority order: i_FlushE=1 -> E loads bubble (flush wins over stall); else i_StallE=1 -> E holds its value; else E loads the D inputs.
REQ-019 D inputs with i_ValidD=0 load E as a bubble regardless of other D control bits.
REQ-020 M stage: i_StallE=1 and i_FlushE=0 -> M loads bubble; otherwise M loads the E contents of the previous cycle.
REQ-021 W stage always loads M; W never stalls or flushes.
REQ-022 Latency D->E 1 cycle, D->M 2 cycles, D->W 3 cycles when no stall/flush intervenes.
REQ-023 o_RetireCount increments by 1 on each edge where the value loaded into W has Valid=1; wraps modulo 2^CNT_W.
REQ-024 o_BubbleCount increments by 1 per edge where i_FlushE=1 or i_StallE=1 (at most 1 per cycle, both asserted counts once); saturates at 2^BUB_W-1.
REQ-025 Simultaneous i_FlushE and i_StallE: E gets bubble, M gets the old E contents (flush semantics only).
REQ-026 i_StallE held N consecutive cycles: E constant for N cycles, M receives N bubbles, original E instruction enters M on the first edge after stall deasserts.

Reset
REQ-027 i_RST=1 immediately (no clock) forces all stage registers to bubble, all outputs to 0, both counters to 0.
REQ-028 Reset asserted mid-operation discards all in-flight slots; no retire count for discarded slots.
REQ-029 First edge after i_RST deasserts samples D inputs normally.

Verification
REQ-030 Reset release, i_ValidD=1, RegWrite=1, MemtoReg=1, ALUControl=3'b010 -> E at edge1, M RegWrite=1 MemtoReg=1 at edge2, W RegWrite=1 at edge3, o_RetireCount=1 at edge3.
REQ-031 i_FlushE=1 one cycle with valid sw (MemWrite=1) in D -> E all zero, o_MemWriteM stays 0 next cycle, o_BubbleCount=1, retire count unchanged for that slot.
REQ-032 i_StallE=1 for 2 cycles with add (ALUControl=3'b010, RegDst=1) in E -> E holds 3'b010 both cycles, o_ValidM=0 for 2 cycles, add reaches M on edge 3.
REQ-033 i_FlushE=1 and i_StallE=1 together -> E bubble, M receives prior E instruction, o_BubbleCount +1 only.
REQ-034 Async i_RST pulse between edges with 3 valid slots in flight -> all outputs 0 before next edge, o_RetireCount=0.
REQ-035 Preload by running 2^BUB_W stall cycles (BUB_W=4 build) -> o_BubbleCount stops at 15; CNT_W=4 build with 17 valid retires -> o_RetireCount=1.
